// File: rtl/uart_fifo_xcvr.sv
// UART transceiver with TX and RX FIFOs: the TX FIFO feeds the serializer, and the
// deserializer writes each received word with its error flags into the RX FIFO.
// Both ports use valid/ready. A word moves only on a clk edge where valid and ready are both high.
module uart_fifo_xcvr #(
  parameter int CLK_SAMPLES = 4,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic                 tx,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overflow,
  output logic [2:0]           tx_state_dbg,
  output logic [2:0]           rx_state_dbg
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(CLK_SAMPLES);
  localparam int BW  = 3;
  localparam int RXW = DATA_BITS + 2;

  localparam logic [CW-1:0] BIT_LAST   = CW'(CLK_SAMPLES - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'((CLK_SAMPLES >= 4) ? (CLK_SAMPLES / 2 - 1) : 1);
  localparam logic [BW-1:0] DATA_LAST  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST  = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
  logic [AW:0]          tx_wr, tx_rd;
  logic                 tx_empty, tx_full, tx_push, tx_pop;
  logic [DATA_BITS-1:0] tx_head;

  assign tx_empty = (tx_wr == tx_rd);
  assign tx_full  = (tx_wr[AW] != tx_rd[AW]) && (tx_wr[AW-1:0] == tx_rd[AW-1:0]);
  assign tx_ready = !tx_full;
  assign tx_push  = tx_valid && tx_ready;
  assign tx_head  = tx_mem[tx_rd[AW-1:0]];

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr[AW-1:0]] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr <= '0;
      tx_rd <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + 1'b1;
      if (tx_pop)  tx_rd <= tx_rd + 1'b1;
    end
  end

  // ---------------- TX FSM ----------------
  state_t               tx_state;
  logic [CW-1:0]        tx_cnt;
  logic [BW-1:0]        tx_bit;
  logic                 tx_stop;
  logic [DATA_BITS-1:0] tx_shreg;
  logic                 tx_par;
  logic                 tx_par_next;
  logic                 tx_frame_end;

  assign tx_par_next  = (PARITY == 1) ? ~^tx_head : ^tx_head;
  assign tx_frame_end = (tx_state == S_STOP) && (tx_cnt == BIT_LAST) && (tx_stop == STOP_LAST);
  // Popping on the last stop cycle lets the next start bit follow with no idle gap.
  assign tx_pop       = !tx_empty && ((tx_state == S_IDLE) || tx_frame_end);
  assign tx_state_dbg = tx_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= S_IDLE;
      tx       <= 1'b1;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_stop  <= 1'b0;
      tx_shreg <= '0;
      tx_par   <= 1'b0;
    end else begin
      case (tx_state)
        S_IDLE: begin
          tx <= 1'b1;
          if (tx_pop) begin
            tx_shreg <= tx_head;
            tx_par   <= tx_par_next;
            tx_cnt   <= '0;
            tx_state <= S_START;
          end
        end
        S_START: begin
          tx <= 1'b0;
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_state <= S_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          tx <= tx_shreg[0];
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_shreg <= tx_shreg >> 1;
            if (tx_bit == DATA_LAST) begin
              tx_stop  <= 1'b0;
              tx_state <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              tx_bit <= tx_bit + 1'b1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          tx <= tx_par;
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_stop  <= 1'b0;
            tx_state <= S_STOP;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        S_STOP: begin
          tx <= 1'b1;
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_stop == STOP_LAST) begin
              if (tx_pop) begin
                tx_shreg <= tx_head;
                tx_par   <= tx_par_next;
                tx_state <= S_START;
              end else begin
                tx_state <= S_IDLE;
              end
            end else begin
              tx_stop <= 1'b1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: begin
          tx       <= 1'b1;
          tx_state <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------- RX synchronizer ----------------
  logic rx_s1, rx_s2, rx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  // ---------------- RX FSM ----------------
  state_t               rx_state;
  logic [CW-1:0]        rx_cnt;
  logic [BW-1:0]        rx_bit;
  logic                 rx_stop;
  logic [DATA_BITS-1:0] rx_shreg;
  logic                 rx_pe, rx_fe;
  logic                 rx_push;
  logic [RXW-1:0]       rx_word;

  assign rx_state_dbg = rx_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_stop  <= 1'b0;
      rx_shreg <= '0;
      rx_pe    <= 1'b0;
      rx_fe    <= 1'b0;
      rx_push  <= 1'b0;
      rx_word  <= '0;
    end else begin
      rx_push <= 1'b0;
      case (rx_state)
        S_IDLE: begin
          // The falling edge is seen one cycle late, so the counter starts at 1.
          if (rx_d && !rx_s2) begin
            rx_cnt   <= CW'(1);
            rx_pe    <= 1'b0;
            rx_fe    <= 1'b0;
            rx_state <= S_START;
          end
        end
        S_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_state <= rx_s2 ? S_IDLE : S_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shreg <= {rx_s2, rx_shreg[DATA_BITS-1:1]};
            if (rx_bit == DATA_LAST) begin
              rx_stop  <= 1'b0;
              rx_state <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              rx_bit <= rx_bit + 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_pe    <= (PARITY == 1) ? ~(^rx_shreg ^ rx_s2) : (^rx_shreg ^ rx_s2);
            rx_stop  <= 1'b0;
            rx_state <= S_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt <= '0;
            if (rx_stop == STOP_LAST) begin
              rx_word  <= {rx_fe | ~rx_s2, rx_pe, rx_shreg};
              rx_push  <= 1'b1;
              rx_state <= S_IDLE;
            end else begin
              rx_fe   <= rx_fe | ~rx_s2;
              rx_stop <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

  // ---------------- RX FIFO ----------------
  logic [RXW-1:0] rx_mem [FIFO_DEPTH];
  logic [AW:0]    rx_wr, rx_rd;
  logic           rx_empty, rx_full, rx_pop, rx_wr_en;

  assign rx_empty = (rx_wr == rx_rd);
  assign rx_full  = (rx_wr[AW] != rx_rd[AW]) && (rx_wr[AW-1:0] == rx_rd[AW-1:0]);
  assign rx_valid = !rx_empty;
  assign rx_pop   = rx_valid && rx_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still take the word.
  assign rx_wr_en = rx_push && (!rx_full || rx_pop);
  assign {rx_frame_err, rx_parity_err, rx_data} = rx_mem[rx_rd[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rx_wr_en) rx_mem[rx_wr[AW-1:0]] <= rx_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr       <= '0;
      rx_rd       <= '0;
      rx_overflow <= 1'b0;
    end else begin
      if (rx_wr_en) rx_wr <= rx_wr + 1'b1;
      if (rx_pop)   rx_rd <= rx_rd + 1'b1;
      rx_overflow <= rx_push && rx_full && !rx_pop;
    end
  end

endmodule

// File: tb/tb_uart_fifo_xcvr.sv
// Self-checking bench for uart_fifo_xcvr (4 clocks/bit, 8 data bits, even parity, 1 stop bit,
// 4-deep FIFOs): TX framing, loopback, RX error flags, overflow, glitch and reset behaviour.
module tb_uart_fifo_xcvr;

  localparam int CS    = 4;
  localparam int DB    = 8;
  localparam int PAR   = 2;
  localparam int SB    = 1;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx;
  logic          tx;
  logic [DB-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready = 1'b1;
  logic          rx_parity_err, rx_frame_err, rx_overflow;
  logic [2:0]    tx_state_dbg, rx_state_dbg;

  logic loop_en = 1'b0;
  logic rx_drv  = 1'b1;
  assign rx = loop_en ? tx : rx_drv;

  int n_checks = 0;
  int n_errors = 0;
  int ovf_cnt  = 0;
  logic [DB+1:0] exp_q[$];

  uart_fifo_xcvr #(
    .CLK_SAMPLES(CS), .DATA_BITS(DB), .PARITY(PAR), .STOP_BITS(SB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx), .tx(tx),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err), .rx_overflow(rx_overflow),
    .tx_state_dbg(tx_state_dbg), .rx_state_dbg(rx_state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Transmitted bit i of a frame: start, 8 data bits LSB first, parity, stop.
  function automatic logic [63:0] frame_bits(input logic [7:0] d, input logic par, input logic stop);
    logic [63:0] f;
    f = '0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = d[i];
    f[9]  = par;
    f[10] = stop;
    return f;
  endfunction

  // Per-clock view of an 11-bit frame, CS cycles per bit.
  function automatic logic [63:0] expand(input logic [63:0] f);
    logic [63:0] e;
    e = '0;
    for (int j = 0; j < 11 * CS; j++) e[j] = f[j / CS];
    return e;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rx_overflow) ovf_cnt++;
    if (!rst && rx_valid && rx_ready) begin
      if (exp_q.size() == 0) begin
        check("rx_unexpected_word", rx_valid, 1'b0);
      end else begin
        check("rx_word", {rx_frame_err, rx_parity_err, rx_data}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks (called just after a posedge) ----------------
  task automatic write_tx(input logic [7:0] d);
    bit done;
    int n;
    done = 1'b0;
    n = 0;
    tx_valid = 1'b1;
    tx_data  = d;
    while (!done) begin
      @(negedge clk);
      done = tx_ready;
      @(posedge clk);
      n++;
      if (!done && n > 200) begin
        check("tx_ready_timeout", tx_ready, 1'b1);
        done = 1'b1;
      end
    end
    #1 tx_valid = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] d, input logic par, input logic stop, input bit expect_word);
    logic [63:0] f;
    f = frame_bits(d, par, stop);
    if (expect_word) exp_q.push_back({~stop, par ^ (^d), d});
    for (int i = 0; i < 11; i++) begin
      rx_drv = f[i];
      repeat (CS) @(posedge clk);
      #1;
    end
    rx_drv = 1'b1;
    repeat (2 * CS) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 600) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(tag, exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] obs0, obs1;
    logic [7:0]  d;
    bit          pe_inj, fe_inj;
    int          lows;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_tx_ready", tx_ready, 1'b1);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_overflow", rx_overflow, 1'b0);
    check("rst_tx_state", tx_state_dbg, 3'd0);
    check("rst_rx_state", rx_state_dbg, 3'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // TX framing of 0xA5: first 0 two edges after the handshake, 44 cycles of frame
    write_tx(8'hA5);
    @(negedge clk);
    check("tx_high_after_accept", tx, 1'b1);
    @(negedge clk);
    check("tx_high_before_start", tx, 1'b1);
    obs0 = '0;
    for (int j = 0; j < 11 * CS; j++) begin
      @(negedge clk);
      obs0[j] = tx;
    end
    check("tx_frame_a5", obs0, expand(frame_bits(8'hA5, 1'b0, 1'b1)));
    @(negedge clk);
    check("tx_idle_after_frame", tx, 1'b1);
    @(posedge clk);
    #1;

    // Loopback: two back-to-back frames, no idle gap
    loop_en = 1'b1;
    exp_q.push_back({2'b00, 8'hA5});
    exp_q.push_back({2'b00, 8'h3C});
    write_tx(8'hA5);
    write_tx(8'h3C);
    @(negedge clk);
    check("loop_tx_high_before_start", tx, 1'b1);
    obs0 = '0;
    obs1 = '0;
    for (int j = 0; j < 22 * CS; j++) begin
      @(negedge clk);
      if (j < 11 * CS) obs0[j] = tx;
      else obs1[j - 11 * CS] = tx;
    end
    check("loop_tx_frame0", obs0, expand(frame_bits(8'hA5, 1'b0, 1'b1)));
    check("loop_tx_frame1", obs1, expand(frame_bits(8'h3C, 1'b0, 1'b1)));
    @(posedge clk);
    #1;
    wait_drain("loop_drain");
    loop_en = 1'b0;

    // Error detection: bad parity on 0x5A, stop bit 0 on 0xC3
    send_rx(8'h5A, 1'b1, 1'b1, 1'b1);
    send_rx(8'hC3, 1'b0, 1'b0, 1'b1);
    wait_drain("err_drain");

    // Random frames with occasional injected errors
    for (int i = 0; i < 6; i++) begin
      d      = 8'($urandom_range(0, 255));
      pe_inj = ($urandom_range(0, 3) == 0);
      fe_inj = ($urandom_range(0, 3) == 0);
      send_rx(d, (^d) ^ pe_inj, !fe_inj, 1'b1);
    end
    wait_drain("rand_drain");

    // Overflow: five frames into a 4-deep FIFO with no reads
    rx_ready = 1'b0;
    ovf_cnt  = 0;
    for (int i = 1; i <= 5; i++) begin
      d = 8'(i);
      send_rx(d, ^d, 1'b1, i <= DEPTH);
      if (i == DEPTH) check("ovf_none_before_5", ovf_cnt, 0);
    end
    repeat (4) @(posedge clk);
    #1;
    check("ovf_pulse_count", ovf_cnt, 1);
    check("ovf_rx_valid", rx_valid, 1'b1);
    check("ovf_head", rx_data, 8'h01);
    rx_ready = 1'b1;
    wait_drain("ovf_drain");
    repeat (4) @(posedge clk);
    #1;
    check("ovf_empty_after_drain", rx_valid, 1'b0);

    // Glitch: one low cycle on rx must not produce a word
    rx_drv = 1'b0;
    @(posedge clk);
    #1 rx_drv = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("glitch_rx_valid", rx_valid, 1'b0);
    check("glitch_rx_state", rx_state_dbg, 3'd0);
    @(posedge clk);
    #1;

    // Reset in the middle of a TX frame with a second word queued
    write_tx(8'h81);
    write_tx(8'h7E);
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("pre_rst_tx_state", tx_state_dbg, 3'd2);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_tx", tx, 1'b1);
    check("mid_rst_tx_ready", tx_ready, 1'b1);
    check("mid_rst_rx_valid", rx_valid, 1'b0);
    check("mid_rst_tx_state", tx_state_dbg, 3'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (!tx) lows++;
    end
    check("post_rst_no_tx_glitch", lows, 0);
    check("post_rst_tx_ready", tx_ready, 1'b1);
    check("post_rst_rx_valid", rx_valid, 1'b0);
    check("post_rst_exp_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
